stage_write: RTL and testbench



---
 rtl/stage_write.sv | 119 +++++++++++
 tb/tb_stage_write.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stage_write.sv
// Write-back stage: retires results into the register file and sequences precise traps
// (mepc write, mcause write, flush/redirect). Define WB_INSTRET_EN to build the retired-instruction counter.
module stage_write #(
  parameter logic [11:0] MEPC_ADDR   = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  logic [3:0]  wb_exc_cause,
  input  logic [31:2] wb_pc,
  input  logic [4:0]  wb_reg_r,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [31:2] mtvec,
  output logic        trap_csr_we,
  output logic [11:0] trap_csr_addr,
  output logic [31:0] trap_csr_data,
  output logic        flush,
  output logic        redirect,
  output logic [31:2] redirect_pc,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {IDLE, T_EPC, T_CAUSE, T_REDIR} state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] csr_data_q, csr_data_d;
  logic        redir_q, redir_d;
  logic        retire;

  // Trap outputs are computed for the next state so they leave the stage straight from flops.
  always_comb begin
    retire     = (state_q == IDLE) && wb_valid && !wb_exc && !reset;
    state_d    = state_q;
    cause_d    = cause_q;
    csr_we_d   = 1'b0;
    csr_addr_d = '0;
    csr_data_d = '0;
    redir_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_exc) begin
          state_d    = T_EPC;
          cause_d    = {28'b0, wb_exc_cause};
          csr_we_d   = 1'b1;
          csr_addr_d = MEPC_ADDR;
          csr_data_d = {wb_pc, 2'b00};
        end
      end
      T_EPC: begin
        state_d    = T_CAUSE;
        csr_we_d   = 1'b1;
        csr_addr_d = MCAUSE_ADDR;
        csr_data_d = cause_q;
      end
      T_CAUSE: begin
        state_d = T_REDIR;
        redir_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cause_q    <= '0;
      csr_we_q   <= 1'b0;
      csr_addr_q <= '0;
      csr_data_q <= '0;
      redir_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      csr_we_q   <= csr_we_d;
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
      redir_q    <= redir_d;
    end
  end

  // Retire is combinational so the register file samples on the presentation edge.
  assign wb_stall      = (state_q != IDLE) || wb_exc;
  assign rf_we         = retire && (wb_reg_r != 5'd0);
  assign rf_waddr      = retire ? wb_reg_r : 5'd0;
  assign rf_wdata      = retire ? wb_data : 32'd0;
  assign trap_csr_we   = csr_we_q;
  assign trap_csr_addr = csr_addr_q;
  assign trap_csr_data = csr_data_q;
  assign flush         = redir_q;
  assign redirect      = redir_q;
  assign redirect_pc   = redir_q ? mtvec : 30'd0;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q + {63'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_stage_write.sv
// Self-checking bench for stage_write: directed trap/retire scenarios followed by random traffic,
// checked against a queue-of-scheduled-actions reference model.
module tb_stage_write;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_exc;
  logic [3:0]  wb_exc_cause;
  logic [31:2] wb_pc;
  logic [4:0]  wb_reg_r;
  logic [31:0] wb_data;
  logic        wb_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:2] mtvec;
  logic        trap_csr_we;
  logic [11:0] trap_csr_addr;
  logic [31:0] trap_csr_data;
  logic        flush, redirect;
  logic [31:2] redirect_pc;
  logic [63:0] instret;

  int testCount = 0;
  int failCount = 0;

  // Reference model: a trap schedules three future actions; retired instructions bump a counter.
  typedef struct {
    logic        isRedir;
    logic [11:0] addr;
    logic [31:0] data;
  } action_t;
  action_t     pending[$];
  logic [63:0] modelCount = 64'd0;

  localparam logic [3:0] LALIGN = 4'd4;

  stage_write dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_exc(wb_exc),
    .wb_exc_cause(wb_exc_cause), .wb_pc(wb_pc), .wb_reg_r(wb_reg_r), .wb_data(wb_data),
    .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mtvec(mtvec), .trap_csr_we(trap_csr_we), .trap_csr_addr(trap_csr_addr),
    .trap_csr_data(trap_csr_data), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks outputs, then advances the model.
  task automatic applyStimulus(input logic rst, input logic valid, input logic exc,
                               input logic [3:0] cause, input logic [31:2] pc,
                               input logic [4:0] rd, input logic [31:0] data,
                               input logic [31:2] vec);
    logic        busy, doRetire, isRedir, isCsr;
    logic [11:0] expAddr;
    logic [31:0] expData;
    @(negedge clk);
    reset = rst; wb_valid = valid; wb_exc = exc; wb_exc_cause = cause;
    wb_pc = pc; wb_reg_r = rd; wb_data = data; mtvec = vec;
    #1;
    busy     = (pending.size() != 0);
    doRetire = !busy && valid && !exc && !rst;
    isRedir  = busy && pending[0].isRedir;
    isCsr    = busy && !pending[0].isRedir;
    expAddr  = isCsr ? pending[0].addr : 12'd0;
    expData  = isCsr ? pending[0].data : 32'd0;
    checkOutput("wb_stall", {63'd0, wb_stall}, {63'd0, busy || exc});
    checkOutput("rf_we", {63'd0, rf_we}, {63'd0, doRetire && (rd != 5'd0)});
    checkOutput("rf_waddr", {59'd0, rf_waddr}, doRetire ? {59'd0, rd} : 64'd0);
    checkOutput("rf_wdata", {32'd0, rf_wdata}, doRetire ? {32'd0, data} : 64'd0);
    checkOutput("trap_csr_we", {63'd0, trap_csr_we}, {63'd0, isCsr});
    checkOutput("trap_csr_addr", {52'd0, trap_csr_addr}, {52'd0, expAddr});
    checkOutput("trap_csr_data", {32'd0, trap_csr_data}, {32'd0, expData});
    checkOutput("flush", {63'd0, flush}, {63'd0, isRedir});
    checkOutput("redirect", {63'd0, redirect}, {63'd0, isRedir});
    checkOutput("redirect_pc", {34'd0, redirect_pc}, isRedir ? {34'd0, vec} : 64'd0);
`ifdef WB_INSTRET_EN
    checkOutput("instret", instret, modelCount);
`else
    checkOutput("instret", instret, 64'd0);
`endif
    if (rst) begin
      pending.delete();
      modelCount = 64'd0;
    end else begin
      if (busy) void'(pending.pop_front());
      else if (exc) begin
        pending.push_back('{1'b0, 12'h341, {pc, 2'b00}});
        pending.push_back('{1'b0, 12'h342, {28'd0, cause}});
        pending.push_back('{1'b1, 12'd0, 32'd0});
      end
      if (doRetire) modelCount = modelCount + 64'd1;
    end
  endtask

  initial begin
    logic [31:2] vec;
    reset = 1'b1; wb_valid = 1'b0; wb_exc = 1'b0; wb_exc_cause = '0;
    wb_pc = '0; wb_reg_r = '0; wb_data = '0; mtvec = '0;
    vec = 30'h0000_0040;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);

    $display("[TB] retire and x0");
    applyStimulus(0, 1, 0, 0, 30'h10, 5'd5, 32'hDEADBEEF, vec);
    applyStimulus(0, 1, 0, 0, 30'h11, 5'd0, 32'h12345678, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);

    $display("[TB] trap, inputs ignored while trapping, then back-to-back retire");
    applyStimulus(0, 0, 1, LALIGN, 30'h400, 5'd3, 32'h1, vec);
    applyStimulus(0, 1, 0, 0, 30'h401, 5'd7, 32'hAAAA5555, vec);
    applyStimulus(0, 1, 1, 4'd2, 30'h402, 5'd8, 32'h5555AAAA, vec);
    applyStimulus(0, 1, 0, 0, 30'h403, 5'd9, 32'h0BADF00D, vec);
    applyStimulus(0, 1, 0, 0, 30'h10, 5'd10, 32'hCAFEF00D, vec);

    $display("[TB] valid and exc together");
    applyStimulus(0, 1, 1, 4'd6, 30'h3FFF_FFFF, 5'd1, 32'h77, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);

    $display("[TB] reset during mcause write");
    applyStimulus(0, 0, 1, LALIGN, 30'h200, 0, 0, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);

`ifdef WB_INSTRET_EN
    $display("[TB] counter wrap");
    @(negedge clk);
    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    modelCount = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(0, 1, 0, 0, 30'h20, 5'd4, 32'h4, vec);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, vec);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0),
                    4'($urandom), 30'($urandom), 5'($urandom), $urandom, 30'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
